// File: rtl/fast9_scan_sequencer.sv
// FAST9 scan controller: walks every valid center in raster order, fetches the
// center pixel and its 16-pixel Bresenham ring, then hands the window to the matcher.
module fast9_scan_sequencer #(
    parameter int IMG_W  = 180,
    parameter int IMG_H  = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              mem_gnt,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              reg_we,
    output logic [4:0]        reg_idx,
    output logic              eval_req,
    input  logic              eval_ack,
    output logic [ADDR_W-1:0] center_addr,
    output logic [7:0]        center_x,
    output logic [6:0]        center_y
);

    typedef enum logic [2:0] {
        IDLE,
        CENTER,
        RING,
        DRAIN,
        EVAL,
        NEXT,
        DONE
    } stateT;

    localparam logic [7:0]        X_LAST     = 8'(IMG_W - 4);
    localparam logic [6:0]        Y_LAST     = 7'(IMG_H - 4);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(3 * IMG_W + 3);

    stateT             state;
    stateT             nextState;
    logic [3:0]        ringIdx;
    logic [ADDR_W-1:0] centerAddrQ;
    logic [7:0]        xQ;
    logic [6:0]        yQ;
    logic              lastCenter;
    logic              readGranted;

    // Ring offsets dy*IMG_W+dx; negative offsets wrap modulo 2^ADDR_W and the add cancels it.
    function automatic logic [ADDR_W-1:0] ringOffset(input logic [3:0] idx);
        int off;
        case (idx)
            4'd0:    off = -3 * IMG_W;
            4'd1:    off = -3 * IMG_W + 1;
            4'd2:    off = -2 * IMG_W + 2;
            4'd3:    off = -IMG_W + 3;
            4'd4:    off = 3;
            4'd5:    off = IMG_W + 3;
            4'd6:    off = 2 * IMG_W + 2;
            4'd7:    off = 3 * IMG_W + 1;
            4'd8:    off = 3 * IMG_W;
            4'd9:    off = 3 * IMG_W - 1;
            4'd10:   off = 2 * IMG_W - 2;
            4'd11:   off = IMG_W - 3;
            4'd12:   off = -3;
            4'd13:   off = -IMG_W - 3;
            4'd14:   off = -2 * IMG_W - 2;
            default: off = -3 * IMG_W - 1;
        endcase
        return ADDR_W'(off);
    endfunction

    assign lastCenter  = (xQ == X_LAST) && (yQ == Y_LAST);
    assign readGranted = mem_rd_en && mem_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        eval_req  = (state == EVAL);
        case (state)
            IDLE:   if (start) nextState = CENTER;
            CENTER: begin
                mem_rd_en = 1'b1;
                mem_addr  = centerAddrQ;
                if (mem_gnt) nextState = RING;
            end
            RING: begin
                mem_rd_en = 1'b1;
                mem_addr  = centerAddrQ + ringOffset(ringIdx);
                if (mem_gnt && ringIdx == 4'd15) nextState = DRAIN;
            end
            DRAIN:  nextState = EVAL;
            EVAL:   if (eval_ack) nextState = NEXT;
            NEXT:   nextState = lastCenter ? DONE : CENTER;
            DONE:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Scan position and ring index; reg_we/reg_idx trail the granted read by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ringIdx     <= '0;
            centerAddrQ <= '0;
            xQ          <= 8'd3;
            yQ          <= 7'd3;
            reg_we      <= 1'b0;
            reg_idx     <= '0;
        end else begin
            reg_we <= readGranted;
            if (readGranted) reg_idx <= (state == CENTER) ? 5'd16 : {1'b0, ringIdx};
            case (state)
                IDLE: begin
                    ringIdx <= '0;
                    if (start) begin
                        xQ          <= 8'd3;
                        yQ          <= 7'd3;
                        centerAddrQ <= FIRST_ADDR;
                    end
                end
                CENTER: ringIdx <= '0;
                RING:   if (mem_gnt) ringIdx <= ringIdx + 4'd1;
                NEXT: begin
                    if (!lastCenter) begin
                        if (xQ == X_LAST) begin
                            xQ          <= 8'd3;
                            yQ          <= yQ + 7'd1;
                            centerAddrQ <= centerAddrQ + ADDR_W'(7);
                        end else begin
                            xQ          <= xQ + 8'd1;
                            centerAddrQ <= centerAddrQ + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign center_addr = centerAddrQ;
    assign center_x    = xQ;
    assign center_y    = yQ;

endmodule

// File: doc/fast9_scan_sequencer.md
Name: fast9_scan_sequencer

Overview:
Top-level scan controller for the FAST9 corner datapath. It walks every valid center pixel of the frame buffer in raster order. For each center it issues one center read and 16 Bresenham-ring reads over a shared pixel-memory read port, steering returned data into the 17-entry comparison register file. It then hands the loaded window to the contiguity matcher and waits for its completion before advancing. It sits between the frame-buffer arbiter (read grant) and the matcher/counter datapath.

Parameters:
IMG_W, 180, frame width in pixels
IMG_H, 120, frame height in pixels
ADDR_W, 15, pixel-memory address width (must hold IMG_W*IMG_H-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame scan when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last center evaluated
mem_gnt  in  1  shared-port grant; read issued only when high
mem_rd_en  out  1  read request to pixel memory (fixed 1-cycle read latency)
mem_addr  out  ADDR_W  read address
reg_we  out  1  register-file write strobe, aligned with returned data (rd_en issued and granted, delayed 1 cycle)
reg_idx  out  5  write index: 0..15 ring position, 16 center
eval_req  out  1  window loaded; held until eval_ack
eval_ack  in  1  matcher finished with current window
center_addr  out  ADDR_W  linear address of current center
center_x  out  8  current center column
center_y  out  7  current center row

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, mem_rd_en, reg_we, eval_req = 0; mem_addr, center_addr = 0; reg_idx = 0; center_x = 3, center_y = 3. Reset mid-operation aborts immediately; no done pulse.
- Valid centers: x in [3, IMG_W-4], y in [3, IMG_H-4]; raster order, x fastest. center_addr = y*IMG_W + x, updated incrementally (+1 per step, +7 on row change).
- Ring offsets (dx,dy) for idx 0..15: (0,-3)(1,-3)(2,-2)(3,-1)(3,0)(3,1)(2,2)(1,3)(0,3)(-1,3)(-2,2)(-3,1)(-3,0)(-3,-1)(-2,-2)(-1,-3). mem_addr = center_addr + dy*IMG_W + dx; constants folded; no wrap possible for valid centers.
- States:
  IDLE: start=1 -> CENTER, busy=1. Load x=3, y=3, center_addr=3*IMG_W+3.
  CENTER: drive mem_rd_en=1, mem_addr=center_addr, tag 16. On mem_gnt=1 -> RING with idx=0; else hold.
  RING: drive ring idx address. On mem_gnt=1: idx==15 -> DRAIN, else idx+1. On mem_gnt=0: idx holds and the address is stable.
  DRAIN: one cycle for the final reg_we -> EVAL.
  EVAL: eval_req=1 until eval_ack=1 is sampled (the ack cycle included), then -> NEXT. eval_ack outside EVAL is ignored.
  NEXT: if x==IMG_W-4 and y==IMG_H-4 -> DONE. Else advance x (wrap to 3, y+1 at IMG_W-4) -> CENTER.
  DONE: done=1 for one cycle, busy=0 -> IDLE.
- mem_rd_en is high only in CENTER/RING. A read counts only when mem_rd_en & mem_gnt. reg_we/reg_idx are registered copies of (granted, tag), one cycle later.
- start while busy is ignored. eval_ack and start in the same cycle as DONE have no effect.
- Minimum per-center latency with constant grant: 1+16+1+1(EVAL with immediate ack)+1(NEXT) = 20 cycles.

Test Plan:
- Reset mid-RING (idx 7, rst_n low 1 cycle) -> all outputs return to reset values; no done. A later start rescans from (3,3), addr 543.
- start, mem_gnt=1, eval_ack tied high, default params -> first center 543. Ring reads idx0=3, idx4=546, idx8=1083, idx12=540. reg_we pulses 17 times with reg_idx 16,0..15, each one cycle after the read.
- mem_gnt low for 3 cycles at ring idx 5 -> mem_addr holds 543+3+180=726. No reg_we gap misalignment; idx 6 follows only after grant.
- eval_ack delayed 10 cycles -> eval_req stays high 10 cycles then drops. No new reads while waiting. Next center 544.
- IMG_W=8, IMG_H=8 -> centers (3,3),(4,3),(3,4),(4,4) = addrs 27,28,35,36. done pulses once after the 4th ack. start pulses while busy are ignored.
- Full default frame, instant ack -> 19836 eval_req assertions, last center_addr 21056 (x=176, y=116). done after exactly 19836*20+1 cycles from start.
